// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle control FSM: states, opcodes, functs, ALU codes, PC sources.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_PC   = 3'd5,
    S_HALT = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    C_R, C_LW, C_SW, C_BEQ, C_J, C_HALT, C_ILL
  } iclass_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;
  localparam logic [2:0] ALU_SLT = 3'b110;
  localparam logic [2:0] ALU_JMP = 3'b111;

  localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_ALU    = 2'd2;

  // Legality comes from the decoder so R-type funct checking lives in one place.
  function automatic iclass_e classify(input logic [5:0] opcode, input logic legal);
    iclass_e c;
    c = C_ILL;
    if (legal) begin
      case (opcode)
        OP_RTYPE: c = C_R;
        OP_LW:    c = C_LW;
        OP_SW:    c = C_SW;
        OP_BEQ:   c = C_BEQ;
        OP_J:     c = C_J;
        OP_HALT:  c = C_HALT;
        default:  c = C_ILL;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control-to-datapath bundle: memory handshake, ALU/regfile/PC strobes and status.
interface multicycle_ctrl_if #(parameter int RETIRE_W = 32);
  logic [31:0]         mem_rdata;
  logic                mem_ack;
  logic                alu_zero;
  logic                mem_req;
  logic                mem_we;
  logic                mem_addr_sel;
  logic [31:0]         ir;
  logic [2:0]          alu_op;
  logic                alu_src_b;
  logic                reg_write;
  logic                reg_dst;
  logic                mem_to_reg;
  logic                pc_write;
  logic [1:0]          pc_src;
  logic [2:0]          state;
  logic                halted;
  logic                illegal;
  logic [RETIRE_W-1:0] retired;

  modport master (
    input  mem_rdata, mem_ack, alu_zero,
    output mem_req, mem_we, mem_addr_sel, ir, alu_op, alu_src_b, reg_write,
           reg_dst, mem_to_reg, pc_write, pc_src, state, halted, illegal, retired
  );

  modport slave (
    output mem_rdata, mem_ack, alu_zero,
    input  mem_req, mem_we, mem_addr_sel, ir, alu_op, alu_src_b, reg_write,
           reg_dst, mem_to_reg, pc_write, pc_src, state, halted, illegal, retired
  );
endinterface

// File: rtl/multicycle_ctrl_alu_op_decode.sv
// Combinational (opcode, funct) -> (EX-state ALU opcode, legal). No state, zero latency.
module alu_op_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alu_op_o,
  output logic       legal_o
);

  always_comb begin
    alu_op_o = ALU_ADD;
    legal_o  = 1'b1;
    case (opcode_i)
      OP_RTYPE: begin
        case (funct_i)
          FN_ADD:  alu_op_o = ALU_ADD;
          FN_SUB:  alu_op_o = ALU_SUB;
          FN_AND:  alu_op_o = ALU_AND;
          FN_OR:   alu_op_o = ALU_OR;
          FN_XOR:  alu_op_o = ALU_XOR;
          FN_SLT:  alu_op_o = ALU_SLT;
          default: legal_o  = 1'b0;
        endcase
      end
      OP_LW, OP_SW, OP_HALT: alu_op_o = ALU_ADD;
      OP_BEQ:                alu_op_o = ALU_SUB;
      OP_J:                  alu_op_o = ALU_JMP;
      default:               legal_o  = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle IF/ID/EX/MEM/WB/PC control FSM; 2..5 cycles per instruction plus one per mem_ack-low cycle.
// Stalls in IF/MEM holding mem_req/mem_we/mem_addr_sel steady until mem_ack.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int RETIRE_W = 32
) (
  input  logic           clk,
  input  logic           reset,
  multicycle_ctrl_if.master bus
);

  state_e              state_q, state_d;
  logic [31:0]         ir_q, ir_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;
  logic                halted_q, halted_d;
  logic                illegal_q, illegal_d;

  logic [2:0] dec_alu_op;
  logic       dec_legal;
  iclass_e    cls;

  alu_op_decode u_dec (
    .opcode_i (ir_q[31:26]),
    .funct_i  (ir_q[5:0]),
    .alu_op_o (dec_alu_op),
    .legal_o  (dec_legal)
  );

  assign cls = classify(ir_q[31:26], dec_legal);

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IF: begin
        if (bus.mem_ack) begin
          ir_d    = bus.mem_rdata;
          state_d = S_ID;
        end
      end
      S_ID: begin
        if (cls == C_HALT) begin
          halted_d = 1'b1;
          state_d  = S_HALT;
        end else if (cls == C_ILL) begin
          illegal_d = 1'b1;
          state_d   = S_IF;
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        case (cls)
          C_R:        state_d = S_WB;
          C_LW, C_SW: state_d = S_MEM;
          default:    state_d = S_PC;
        endcase
      end
      S_MEM: begin
        if (bus.mem_ack) begin
          if (cls == C_SW) begin
            state_d   = S_IF;
            retired_d = retired_q + RETIRE_W'(1);
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB, S_PC: begin
        state_d   = S_IF;
        retired_d = retired_q + RETIRE_W'(1);
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  // Reset drops any in-flight request; outputs are decoded from state, so no strobe survives it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IF;
      ir_q      <= '0;
      retired_q <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    bus.mem_req      = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_addr_sel = 1'b0;
    bus.alu_op       = ALU_ADD;
    bus.alu_src_b    = 1'b0;
    bus.reg_write    = 1'b0;
    bus.reg_dst      = 1'b0;
    bus.mem_to_reg   = 1'b0;
    bus.pc_write     = 1'b0;
    bus.pc_src       = PC_SRC_SEQ;
    case (state_q)
      S_IF: bus.mem_req = 1'b1;
      S_ID: bus.pc_write = 1'b1;
      S_EX: begin
        bus.alu_op    = dec_alu_op;
        bus.alu_src_b = (cls == C_LW) || (cls == C_SW);
      end
      S_MEM: begin
        bus.mem_req      = 1'b1;
        bus.mem_addr_sel = 1'b1;
        bus.mem_we       = (cls == C_SW);
      end
      S_WB: begin
        bus.reg_write  = 1'b1;
        bus.reg_dst    = (cls == C_R);
        bus.mem_to_reg = (cls == C_LW);
      end
      S_PC: begin
        if (cls == C_BEQ) begin
          bus.pc_src   = PC_SRC_BRANCH;
          bus.pc_write = bus.alu_zero;
        end else begin
          bus.pc_src   = PC_SRC_ALU;
          bus.pc_write = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.ir      = ir_q;
  assign bus.state   = state_q;
  assign bus.halted  = halted_q;
  assign bus.illegal = illegal_q;
  assign bus.retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: per-instruction state-trace and strobe model from the ISA rules.
module tb_multicycle_ctrl;

  localparam int K_R = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_J = 4, K_HALT = 5, K_ILL = 6;
  localparam int T_IF = 0, T_ID = 1, T_EX = 2, T_MEM = 3, T_WB = 4, T_PC = 5, T_HALT = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  int          model_retired = 0;
  logic        model_ill = 1'b0;
  logic        model_halt = 1'b0;

  multicycle_ctrl_if #(.RETIRE_W(32)) bus ();

  multicycle_ctrl #(.RETIRE_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] outs();
    return {bus.mem_req, bus.mem_we, bus.mem_addr_sel, bus.alu_op, bus.alu_src_b,
            bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.pc_write, bus.pc_src};
  endfunction

  function automatic void classify(input logic [31:0] instr, output int kind, output logic [2:0] rop);
    rop  = 3'b001;
    kind = K_ILL;
    case (instr[31:26])
      6'b000000: begin
        kind = K_R;
        case (instr[5:0])
          6'd32:   rop = 3'b001;
          6'd34:   rop = 3'b010;
          6'd36:   rop = 3'b011;
          6'd37:   rop = 3'b100;
          6'd38:   rop = 3'b101;
          6'd42:   rop = 3'b110;
          default: kind = K_ILL;
        endcase
      end
      6'b100011: kind = K_LW;
      6'b101011: kind = K_SW;
      6'b000100: kind = K_BEQ;
      6'b000010: kind = K_J;
      6'b111111: kind = K_HALT;
      default:   kind = K_ILL;
    endcase
  endfunction

  // Expected strobe vector, same packing as outs().
  function automatic logic [12:0] exp_out(input int st, input int kind, input logic [2:0] rop, input logic z);
    logic req, we, asel, srcb, rw, dst, m2r, pcw;
    logic [2:0] op;
    logic [1:0] psrc;
    req = 0; we = 0; asel = 0; srcb = 0; rw = 0; dst = 0; m2r = 0; pcw = 0;
    op = 3'b001; psrc = 2'd0;
    case (st)
      T_IF: req = 1;
      T_ID: pcw = 1;
      T_EX: begin
        if (kind == K_R) op = rop;
        else if (kind == K_BEQ) op = 3'b010;
        else if (kind == K_J) op = 3'b111;
        else srcb = 1;
      end
      T_MEM: begin req = 1; asel = 1; we = (kind == K_SW); end
      T_WB: begin rw = 1; dst = (kind == K_R); m2r = (kind == K_LW); end
      T_PC: begin
        if (kind == K_BEQ) begin psrc = 2'd1; pcw = z; end
        else begin psrc = 2'd2; pcw = 1; end
      end
      default: ;
    endcase
    return {req, we, asel, op, srcb, rw, dst, m2r, pcw, psrc};
  endfunction

  function automatic logic [31:0] mk_instr(input logic [5:0] opc, input logic [5:0] fn);
    logic [31:0] r;
    r = $urandom;
    r[31:26] = opc;
    r[5:0] = fn;
    return r;
  endfunction

  task automatic run_instr(input logic [31:0] instr, input int wif, input int wmem,
                           input logic zero, input int abort_at);
    int kind;
    logic [2:0] rop;
    int exp_q[$];
    logic aborted;
    logic ack;
    int st;
    classify(instr, kind, rop);
    aborted = 1'b0;
    for (int i = 0; i <= wif; i++) exp_q.push_back(T_IF);
    exp_q.push_back(T_ID);
    if (kind != K_ILL && kind != K_HALT) exp_q.push_back(T_EX);
    if (kind == K_LW || kind == K_SW)
      for (int i = 0; i <= wmem; i++) exp_q.push_back(T_MEM);
    if (kind == K_R || kind == K_LW) exp_q.push_back(T_WB);
    if (kind == K_BEQ || kind == K_J) exp_q.push_back(T_PC);

    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      st = exp_q[k];
      if (k == abort_at) begin
        reset = 1'b1;
        bus.mem_ack = 1'b1;
        aborted = 1'b1;
        break;
      end
      if (st == T_IF || st == T_MEM) ack = (k + 1 >= exp_q.size()) || (exp_q[k+1] != st);
      else ack = 1'($urandom_range(0, 1));
      bus.mem_ack   = ack;
      bus.mem_rdata = (st == T_IF && ack) ? instr : $urandom;
      bus.alu_zero  = (st == T_PC) ? zero : 1'($urandom_range(0, 1));
      #1;
      n_checks++;
      if (bus.state !== 3'(st))
        $display("FAIL state[%0d] instr=%h: got %0d expected %0d", k, instr, bus.state, st);
      if (bus.state !== 3'(st)) n_fail++;
      n_checks++;
      if (outs() !== exp_out(st, kind, rop, zero)) begin
        $display("FAIL strobes[%0d] instr=%h st=%0d: got %b expected %b", k, instr, st,
                 outs(), exp_out(st, kind, rop, zero));
        n_fail++;
      end
      if (k > wif) begin
        n_checks++;
        if (bus.ir !== instr) begin
          $display("FAIL ir: got %h expected %h", bus.ir, instr);
          n_fail++;
        end
      end
    end

    if (!aborted) begin
      @(posedge clk);
      #1;
      if (kind == K_ILL) model_ill = 1'b1;
      else if (kind == K_HALT) model_halt = 1'b1;
      else model_retired++;
      n_checks++;
      if (bus.retired !== 32'(model_retired) || bus.illegal !== model_ill || bus.halted !== model_halt) begin
        $display("FAIL status instr=%h: got retired=%0d ill=%b halt=%b expected retired=%0d ill=%b halt=%b",
                 instr, bus.retired, bus.illegal, bus.halted, model_retired, model_ill, model_halt);
        n_fail++;
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    n_checks++;
    if (bus.state !== 3'd0 || bus.ir !== 32'd0 || bus.retired !== 32'd0 ||
        bus.halted !== 1'b0 || bus.illegal !== 1'b0) begin
      $display("FAIL %s regs: got state=%0d ir=%h retired=%0d halt=%b ill=%b expected 0", tag,
               bus.state, bus.ir, bus.retired, bus.halted, bus.illegal);
      n_fail++;
    end
    n_checks++;
    if (outs() !== exp_out(T_IF, K_R, 3'b001, 1'b0)) begin
      $display("FAIL %s strobes: got %b expected %b", tag, outs(), exp_out(T_IF, K_R, 3'b001, 1'b0));
      n_fail++;
    end
    model_retired = 0;
    model_ill = 1'b0;
    model_halt = 1'b0;
  endtask

  task automatic test_reset();
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    bus.alu_zero = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_state("reset");
  endtask

  task automatic test_add();
    run_instr(mk_instr(6'b000000, 6'b100000), 0, 0, 1'b0, -1);
  endtask

  task automatic test_lw_delay();
    run_instr(mk_instr(6'b100011, 6'($urandom)), 0, 3, 1'b0, -1);
  endtask

  task automatic test_beq();
    run_instr(mk_instr(6'b000100, 6'($urandom)), 0, 0, 1'b1, -1);
    run_instr(mk_instr(6'b000100, 6'($urandom)), 1, 0, 1'b0, -1);
  endtask

  task automatic test_j_illegal();
    run_instr(mk_instr(6'b000010, 6'($urandom)), 0, 0, 1'b0, -1);
    run_instr(mk_instr(6'b001111, 6'($urandom)), 0, 0, 1'b0, -1);
    run_instr(mk_instr(6'b000000, 6'b000000), 2, 0, 1'b0, -1);
  endtask

  // SW aborted in its second MEM cycle, with a late ack during the reset cycle.
  task automatic test_reset_mid_mem();
    run_instr(mk_instr(6'b101011, 6'($urandom)), 0, 5, 1'b0, 4);
    @(negedge clk);
    reset = 1'b0;
    bus.mem_ack = 1'b0;
    #1;
    check_reset_state("reset_mid_mem");
  endtask

  task automatic test_random();
    logic [5:0] opcs [7];
    logic [5:0] fns [7];
    logic [5:0] opc, fn;
    opcs = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001111, 6'b000000};
    fns  = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd38, 6'd42, 6'd1};
    for (int n = 0; n < 60; n++) begin
      opc = opcs[$urandom_range(0, 6)];
      fn = (opc == 6'b000000) ? fns[$urandom_range(0, 6)] : 6'($urandom);
      run_instr(mk_instr(opc, fn), $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), -1);
    end
  endtask

  task automatic test_halt();
    run_instr(mk_instr(6'b111111, 6'($urandom)), 1, 0, 1'b0, -1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      bus.mem_ack = 1'(k % 2);
      bus.mem_rdata = $urandom;
      bus.alu_zero = 1'($urandom_range(0, 1));
      #1;
      n_checks++;
      if (bus.state !== 3'd6 || outs() !== exp_out(T_HALT, K_HALT, 3'b001, 1'b0) || bus.halted !== 1'b1) begin
        $display("FAIL halt_hold[%0d]: got state=%0d strobes=%b halt=%b expected state=6 strobes=%b halt=1",
                 k, bus.state, outs(), bus.halted, exp_out(T_HALT, K_HALT, 3'b001, 1'b0));
        n_fail++;
      end
    end
    @(negedge clk);
    bus.mem_ack = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_state("halt_recover");
    run_instr(mk_instr(6'b000000, 6'b101010), 0, 0, 1'b0, -1);
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_delay();
    test_beq();
    test_j_illegal();
    test_reset_mid_mem();
    test_random();
    test_halt();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
